// File: rtl/piso_sched_if.sv
// ============================================================================
// piso_sched_if : requester-side handshake bundle for piso_sched  (rev 1.0)
// ============================================================================
`default_nettype none

interface piso_sched_if #(
  parameter int W = 4
);
  logic         req0;
  logic         req1;
  logic [W-1:0] din0;
  logic [W-1:0] din1;
  logic         gnt0;
  logic         gnt1;

  modport master (output req0, req1, din0, din1, input gnt0, gnt1);
  modport slave  (input req0, req1, din0, din1, output gnt0, gnt1);
endinterface

`default_nettype wire

// File: rtl/piso_sched.sv
// ============================================================================
// piso_sched : two-requester round-robin scheduler driving a PISO load port
// rev 1.0
// ============================================================================
`default_nettype none

module piso_sched #(
  parameter int W   = 4,
  parameter int GAP = 1
) (
  input  wire logic         clk,
  input  wire logic         rst,
  piso_sched_if.slave       bus,
  output logic              piso_load,
  output logic [W-1:0]      piso_pin,
  output logic              busy,
  output logic              done,
  output logic              owner,
  output logic [7:0]        frames
);

  localparam int CW = $clog2(W);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
  localparam logic [GW-1:0] GAP_LAST = (GAP > 0) ? GW'(GAP - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic          load_q, load_d, busy_q, busy_d, done_q, done_d;
  logic          owner_q, owner_d, prev_q, prev_d;
  logic [W-1:0]  pin_q, pin_d;
  logic [7:0]    frames_q, frames_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic          win;

  always_comb begin
    state_d  = state_q;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    load_d   = 1'b0;
    done_d   = 1'b0;
    busy_d   = busy_q;
    owner_d  = owner_q;
    prev_d   = prev_q;
    pin_d    = pin_q;
    frames_d = frames_q;
    cnt_d    = cnt_q;
    gcnt_d   = gcnt_q;
    win      = (bus.req0 & bus.req1) ? ~prev_q : bus.req1;

    case (state_q)
      S_IDLE: begin
        if (bus.req0 | bus.req1) begin
          state_d = S_LOAD;
          pin_d   = win ? bus.din1 : bus.din0;
          owner_d = win;
          prev_d  = win;
          gnt0_d  = ~win;
          gnt1_d  = win;
          load_d  = 1'b1;
          busy_d  = 1'b1;
        end
      end
      S_LOAD: begin
        state_d = S_SHIFT;
        cnt_d   = CNT_LAST;
      end
      S_SHIFT: begin
        if (cnt_q == '0) begin
          frames_d = frames_q + 8'd1;
          if (GAP > 0) begin
            state_d = S_GAP;
            gcnt_d  = GAP_LAST;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_d  = cnt_q - CW'(1);
          // done is registered, so raise it one cycle ahead of the zero count
          done_d = (cnt_q == CW'(1));
        end
      end
      S_GAP: begin
        if (gcnt_q == '0) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          gcnt_d = gcnt_q - GW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // prev resets to 1 so requester 0 wins the first tie
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      load_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      owner_q  <= 1'b0;
      prev_q   <= 1'b1;
      pin_q    <= '0;
      frames_q <= 8'd0;
      cnt_q    <= '0;
      gcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      load_q   <= load_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      owner_q  <= owner_d;
      prev_q   <= prev_d;
      pin_q    <= pin_d;
      frames_q <= frames_d;
      cnt_q    <= cnt_d;
      gcnt_q   <= gcnt_d;
    end
  end

  assign bus.gnt0  = gnt0_q;
  assign bus.gnt1  = gnt1_q;
  assign piso_load = load_q;
  assign piso_pin  = pin_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign owner     = owner_q;
  assign frames    = frames_q;

endmodule

`default_nettype wire

// File: tb/tb_piso_sched.sv
// ============================================================================
// tb_piso_sched : scoreboard bench for piso_sched (GAP=1 and GAP=0 instances)
// rev 1.0
// ============================================================================
`default_nettype none

module tb_piso_sched;
  localparam int W = 4;

  typedef struct {
    logic         g0;
    logic         g1;
    logic [W-1:0] pin;
    logic         own;
    int           per;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  piso_sched_if #(.W(W)) ia();
  piso_sched_if #(.W(W)) ib();

  logic         a_load, a_busy, a_done, a_owner;
  logic [W-1:0] a_pin;
  logic [7:0]   a_frames;
  logic         b_load, b_busy, b_done, b_owner;
  logic [W-1:0] b_pin;
  logic [7:0]   b_frames;

  piso_sched #(.W(W), .GAP(1)) dut_a (
    .clk(clk), .rst(rst), .bus(ia.slave),
    .piso_load(a_load), .piso_pin(a_pin), .busy(a_busy),
    .done(a_done), .owner(a_owner), .frames(a_frames)
  );

  piso_sched #(.W(W), .GAP(0)) dut_b (
    .clk(clk), .rst(rst), .bus(ib.slave),
    .piso_load(b_load), .piso_pin(b_pin), .busy(b_busy),
    .done(b_done), .owner(b_owner), .frames(b_frames)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int a_last = 0, a_loadc = 0, a_dones = 0;
  int b_last = 0, b_loadc = 0, b_dones = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input int d, input logic g0, input logic g1,
                      input logic [W-1:0] pin, input logic own, input int per);
    exp_t e;
    e.g0 = g0; e.g1 = g1; e.pin = pin; e.own = own; e.per = per;
    if (d == 0) qa.push_back(e);
    else        qb.push_back(e);
  endtask

  // Monitor for the GAP=1 instance
  always @(negedge clk) begin
    if (a_load | ia.gnt0 | ia.gnt1) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_load", 1, 0);
      end else begin
        ea = qa.pop_front();
        chk("a_gnt0", ia.gnt0, ea.g0);
        chk("a_gnt1", ia.gnt1, ea.g1);
        chk("a_load", a_load, 1);
        chk("a_pin", a_pin, ea.pin);
        chk("a_owner", a_owner, ea.own);
        chk("a_busy_in_load", a_busy, 1);
        if (ea.per > 0) chk("a_period", cyc - a_last, ea.per);
      end
      a_last  = cyc;
      a_loadc = cyc;
    end
    if (a_done) begin
      chk("a_done_latency", cyc - a_loadc, W);
      a_dones++;
    end
  end

  // Monitor for the GAP=0 instance
  always @(negedge clk) begin
    if (b_load | ib.gnt0 | ib.gnt1) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_load", 1, 0);
      end else begin
        eb = qb.pop_front();
        chk("b_gnt0", ib.gnt0, eb.g0);
        chk("b_gnt1", ib.gnt1, eb.g1);
        chk("b_load", b_load, 1);
        chk("b_pin", b_pin, eb.pin);
        chk("b_owner", b_owner, eb.own);
        if (eb.per > 0) chk("b_period", cyc - b_last, eb.per);
      end
      b_last  = cyc;
      b_loadc = cyc;
    end
    if (b_done) begin
      chk("b_done_latency", cyc - b_loadc, W);
      b_dones++;
    end
  end

  task automatic wait_gnt(input int d, input int which, input string nm);
    bit ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (d == 0 && which == 0 && ia.gnt0) ok = 1;
      if (d == 0 && which == 1 && ia.gnt1) ok = 1;
      if (d == 1 && which == 0 && ib.gnt0) ok = 1;
      if (d == 1 && which == 1 && ib.gnt1) ok = 1;
      if (ok) break;
    end
    if (!ok) chk({nm, "_gnt_timeout"}, 0, 1);
  endtask

  task automatic wait_idle(input int d, input string nm);
    bit ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if ((d == 0 && !a_busy) || (d == 1 && !b_busy)) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk({nm, "_idle_timeout"}, 0, 1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt, g, d, dn;
    bit ok;
    ia.req0 = 0; ia.req1 = 0; ia.din0 = '0; ia.din1 = '0;
    ib.req0 = 0; ib.req1 = 0; ib.din0 = '0; ib.din1 = '0;

    // Reset values
    @(negedge clk);
    chk("reset_outputs_a", {ia.gnt0, ia.gnt1, a_load, a_pin, a_busy, a_done, a_owner, a_frames}, 0);
    chk("reset_outputs_b", {ib.gnt0, ib.gnt1, b_load, b_pin, b_busy, b_done, b_owner, b_frames}, 0);
    rst = 1'b1;

    // Single requester 0
    ia.din0 = 4'b1010;
    push(0, 1, 0, 4'b1010, 0, 0);
    ia.req0 = 1;
    wait_gnt(0, 0, "t1");
    ia.req0 = 0;
    busy_cnt = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (a_busy) busy_cnt++;
      else break;
    end
    chk("t1_busy_cycles", busy_cnt, 6);
    chk("t1_frames", a_frames, 1);
    chk("t1_dones", a_dones, 1);
    chk("t1_pin_held_idle", a_pin, 4'b1010);

    // Simultaneous requests after reset
    do_reset();
    ia.din0 = 4'b1010; ia.din1 = 4'b0101;
    push(0, 1, 0, 4'b1010, 0, 0);
    push(0, 0, 1, 4'b0101, 1, 7);
    ia.req0 = 1; ia.req1 = 1;
    wait_gnt(0, 0, "t2a");
    ia.req0 = 0;
    wait_gnt(0, 1, "t2b");
    ia.req1 = 0;
    wait_idle(0, "t2");
    chk("t2_frames", a_frames, 2);

    // Both held for four frames
    do_reset();
    ia.din0 = 4'b0011; ia.din1 = 4'b1100;
    push(0, 1, 0, 4'b0011, 0, 0);
    push(0, 0, 1, 4'b1100, 1, 7);
    push(0, 1, 0, 4'b0011, 0, 7);
    push(0, 0, 1, 4'b1100, 1, 7);
    ia.req0 = 1; ia.req1 = 1;
    wait_gnt(0, 0, "t3a");
    wait_gnt(0, 1, "t3b");
    wait_gnt(0, 0, "t3c");
    wait_gnt(0, 1, "t3d");
    ia.req0 = 0; ia.req1 = 0;
    wait_idle(0, "t3");
    chk("t3_frames", a_frames, 4);
    chk("t3_owner_last", a_owner, 1);

    // Reset during the 2nd SHIFT cycle
    do_reset();
    ia.din0 = 4'b0110;
    push(0, 1, 0, 4'b0110, 0, 0);
    ia.req0 = 1;
    wait_gnt(0, 0, "t4a");
    ia.req0 = 0;
    dn = a_dones;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t4_reset_outputs", {ia.gnt0, ia.gnt1, a_load, a_pin, a_busy, a_done, a_owner, a_frames}, 0);
    repeat (4) @(negedge clk);
    chk("t4_no_done", a_dones, dn);
    ia.din0 = 4'b1110; ia.din1 = 4'b1001;
    push(0, 1, 0, 4'b1110, 0, 0);
    push(0, 0, 1, 4'b1001, 1, 7);
    ia.req0 = 1; ia.req1 = 1;
    rst = 1'b1;
    wait_gnt(0, 0, "t4b");
    ia.req0 = 0;
    chk("t4_frames_zero", a_frames, 0);
    wait_gnt(0, 1, "t4c");
    ia.req1 = 0;
    wait_idle(0, "t4");
    chk("t4_frames", a_frames, 2);
    chk("t4_dones", a_dones, dn + 2);

    // GAP=0 instance, requester 1 held
    ib.din1 = 4'b1011;
    push(1, 0, 1, 4'b1011, 1, 0);
    push(1, 0, 1, 4'b1011, 1, 6);
    push(1, 0, 1, 4'b1011, 1, 6);
    ib.req1 = 1;
    wait_gnt(1, 1, "t5a");
    wait_gnt(1, 1, "t5b");
    wait_gnt(1, 1, "t5c");
    ib.req1 = 0;
    busy_cnt = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (b_busy) busy_cnt++;
      else break;
    end
    chk("t5_busy_cycles", busy_cnt, 5);
    chk("t5_frames", b_frames, 3);

    // Frame counter wrap after 256 frames
    do_reset();
    ia.din0 = 4'b0001;
    for (int i = 0; i < 256; i++) push(0, 1, 0, 4'b0001, 0, (i == 0) ? 0 : 7);
    ia.req0 = 1;
    g = 0; d = 0; ok = 0;
    for (int i = 0; i < 256 * 8 + 50; i++) begin
      @(negedge clk);
      if (ia.gnt0) begin
        g++;
        if (g == 256) ia.req0 = 0;
      end
      if (a_done) begin
        d++;
        if (d == 256) begin
          chk("t6_before_wrap", a_frames, 255);
          @(negedge clk);
          chk("t6_wrap", a_frames, 0);
          ok = 1;
          break;
        end
      end
    end
    if (!ok) chk("t6_wrap_timeout", 0, 1);
    ia.req0 = 0;
    wait_idle(0, "t6");
    chk("t6_frames_after", a_frames, 0);

    repeat (5) @(negedge clk);
    chk("a_queue_empty", qa.size(), 0);
    chk("b_queue_empty", qb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
